// File: rtl/light_dp_pkg.sv
// Shared definitions for the traffic-light datapath: one-hot state bit positions,
// configuration select codes and default widths.
package light_dp_pkg;

  localparam int unsigned STATE_W = 5;

  // One-hot bit positions; INIT..R double as indices into the duration arrays.
  localparam int unsigned S_INIT = 0;
  localparam int unsigned S_G    = 1;
  localparam int unsigned S_Y    = 2;
  localparam int unsigned S_R    = 3;
  localparam int unsigned S_END  = 4;

  localparam logic [STATE_W-1:0] S_ZVEC = '0;

  localparam int unsigned CNT_W_DEF = 8;

  localparam int unsigned CFG_SEL_W = 2;
  localparam logic [CFG_SEL_W-1:0] CFG_INIT = 2'd0;
  localparam logic [CFG_SEL_W-1:0] CFG_G    = 2'd1;
  localparam logic [CFG_SEL_W-1:0] CFG_Y    = 2'd2;
  localparam logic [CFG_SEL_W-1:0] CFG_R    = 2'd3;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/light_dp.sv
// Traffic-light datapath: phase counter, programmable phase durations with commit
// at end of INIT, emergency pass pulse with holdoff, registered lamps, state check.
module light_dp
  import light_dp_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned INIT_DUR_RST = 4,
  parameter int unsigned G_DUR_RST    = 20,
  parameter int unsigned Y_DUR_RST    = 5,
  parameter int unsigned R_DUR_RST    = 15,
  parameter int unsigned PASS_HOLDOFF = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [STATE_W-1:0]   curr_state,
  input  logic                 dp_cnt_rst,
  output logic [STATE_W-1:0]   fb_flags,
  output logic                 pass,
  input  logic                 emg_req,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CFG_SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0]     cfg_data,
  output logic                 lamp_r,
  output logic                 lamp_y,
  output logic                 lamp_g,
  output logic                 state_err
);

  localparam int unsigned HOLD_W = $clog2(PASS_HOLDOFF + 1);

  typedef logic [CNT_W-1:0] dur_t;

  localparam dur_t CNT_MAX = '1;
  localparam dur_t RST_DUR [4] = '{dur_t'(INIT_DUR_RST), dur_t'(G_DUR_RST),
                                   dur_t'(Y_DUR_RST), dur_t'(R_DUR_RST)};

  // Last-cycle threshold; a zero duration behaves as one cycle.
  function automatic dur_t dur_thr(input dur_t d);
    return (d == '0) ? '0 : d - dur_t'(1);
  endfunction

  dur_t              cnt_q, cnt_d;
  dur_t              shadow_q [4];
  dur_t              active_q [4];
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pass_q, pass_d;
  logic [2:0]        lamp_q, lamp_d;
  logic              state_err_q;
  logic              onehot, commit, emg_rise;

  sync_edge u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .async_i (emg_req),
    .rise_o  (emg_rise)
  );

  assign onehot = $onehot(curr_state);

  always_comb begin
    fb_flags = '0;
    for (int i = 0; i < 4; i++) begin
      fb_flags[i] = curr_state[i] && (cnt_q >= dur_thr(active_q[i]));
    end
  end

  // Durations only switch over at the end of INIT; writes stall on that one cycle.
  assign commit    = curr_state[S_INIT] & fb_flags[S_INIT];
  assign cfg_ready = ~commit;

  always_comb begin
    cnt_d = cnt_q;
    if (dp_cnt_rst) begin
      cnt_d = '0;
    end else if (onehot && !curr_state[S_END] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + dur_t'(1);
    end
  end

  always_comb begin
    pass_d = emg_rise && (hold_q == '0) && !curr_state[S_END];
    hold_d = hold_q;
    if (pass_d) begin
      hold_d = HOLD_W'(PASS_HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  // Lamp vector is {r, y, g}; anything not decoded as G, Y or END falls back to red.
  always_comb begin
    lamp_d = 3'b100;
    if (onehot) begin
      if (curr_state[S_G]) begin
        lamp_d = 3'b001;
      end else if (curr_state[S_Y]) begin
        lamp_d = 3'b010;
      end else if (curr_state[S_END]) begin
        lamp_d = 3'b000;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      shadow_q    <= RST_DUR;
      active_q    <= RST_DUR;
      hold_q      <= '0;
      pass_q      <= 1'b0;
      lamp_q      <= 3'b100;
      state_err_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      pass_q <= pass_d;
      lamp_q <= lamp_d;
      if (cfg_valid && cfg_ready) begin
        shadow_q[cfg_sel] <= cfg_data;
      end
      if (commit) begin
        active_q <= shadow_q;
      end
      if (!onehot) begin
        state_err_q <= 1'b1;
      end
    end
  end

  assign pass      = pass_q;
  assign lamp_r    = lamp_q[2];
  assign lamp_y    = lamp_q[1];
  assign lamp_g    = lamp_q[0];
  assign state_err = state_err_q;

endmodule

// File: doc/light_dp.md
# light_dp

Datapath stage paired with the traffic-light sequencing FSM. Consumes the FSM's one-hot `curr_state` and `dp_cnt_rst`, and runs the phase-duration counter. Produces the per-phase completion flags (`fb_flags`) and the `pass` override pulse that the FSM consumes. Also holds the programmable phase durations, drives the registered lamp outputs, and flags illegal state encodings.

## Interface
Parameters:
- `CNT_W`, 8 — phase counter and duration width.
- `INIT_DUR_RST`, 4 — reset value of the INIT duration.
- `G_DUR_RST`, 20 — reset value of the GREEN duration.
- `Y_DUR_RST`, 5 — reset value of the YELLOW duration.
- `R_DUR_RST`, 15 — reset value of the RED duration.
- `PASS_HOLDOFF`, 16 — minimum number of cycles between two `pass` pulses.

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — asynchronous, active-high.
- `curr_state` in `STATE_W` — one-hot FSM state: bit `S_INIT`, `S_G`, `S_Y`, `S_R`, `S_END`.
- `dp_cnt_rst` in 1 — synchronous counter clear.
- `fb_flags` out `STATE_W` — phase-done flags, one bit per state.
- `pass` out 1 — one-cycle override pulse to the FSM.
- `emg_req` in 1 — asynchronous emergency request, level.
- `cfg_valid` in 1 — configuration write request.
- `cfg_ready` out 1 — configuration write accepted.
- `cfg_sel` in 2 — target: 0 INIT, 1 G, 2 Y, 3 R.
- `cfg_data` in `CNT_W` — duration value in cycles.
- `lamp_r`, `lamp_y`, `lamp_g` out 1 each — lamp drives.
- `state_err` out 1 — sticky flag for an illegal `curr_state` encoding.

## Operation
- **Counter.** `cnt` is `CNT_W` bits and resets to 0.
  - `dp_cnt_rst` sets it to 0, and takes priority.
  - Otherwise it increments in INIT, G, Y and R, saturating at all-ones.
  - It holds in END and on any non-one-hot state.
- **Effective duration.** `dur_eff = (dur==0) ? 1 : dur`.
- **Flags.** `fb_flags[S_x] = curr_state[S_x] && (cnt >= dur_eff_x - 1)` for x in INIT, G, Y, R. The `>=` comparison keeps a phase terminating even after a duration is shortened mid-phase. `fb_flags[S_END]` is 0.
  - Result: a phase entered with `cnt=0` lasts exactly `dur_eff` cycles.
- **Duration registers.** Two sets, `shadow_*` and `active_*`. Both reset to `*_DUR_RST`.
  - `cfg_valid && cfg_ready` writes `cfg_data` into `shadow[cfg_sel]`.
  - Commit event: `curr_state[S_INIT] && fb_flags[S_INIT]`. On that cycle all `active_*` load from `shadow_*`.
  - `cfg_ready` is the inverse of the commit event, so a write is never lost to a commit.
  - New durations therefore take effect from the next G phase onward, never mid-cycle.
- **Pass path.**
  - `emg_req` passes through a 2-flop synchronizer, then a rising-edge detector.
  - The edge fires a registered `pass` pulse when the holdoff counter is 0, and the holdoff counter then loads `PASS_HOLDOFF`.
  - Edges that arrive while the holdoff counter is non-zero are dropped.
  - `pass` is suppressed in END.
- **Lamps.** Registered decode of `curr_state`:
  - G → `g`.
  - Y → `y`.
  - R or INIT → `r`.
  - END → all lamps off.
  - Illegal encoding → `r`, the safe state.
- **Error flag.** `state_err` sets when `curr_state` is not one-hot (zero bits set or more than one). It clears only on `reset`.

## Timing
- **Reset values:**
  - `cnt` = 0.
  - `pass` = 0.
  - Lamps: `lamp_r` = 1, `lamp_y` = 0, `lamp_g` = 0.
  - `state_err` = 0.
  - `cfg_ready` = 1.
  - Synchronizer flops = 0.
  - Holdoff counter = 0.
- `fb_flags` is combinational from registers, so it has zero latency relative to `cnt` and `curr_state`.
- Lamps lag `curr_state` by 1 cycle.
- `pass` asserts on the 3rd rising edge after `emg_req` meets setup (2 synchronizer flops plus the output register). It is high for exactly 1 cycle.
- A `cfg` write is visible in shadow 1 cycle after the handshake, and in active at the next commit event.
- Simultaneous `dp_cnt_rst` and an increment condition: the clear wins.
- Simultaneous `emg_req` edge and END state: no pulse is produced, and the holdoff counter is not loaded.
- `reset` asserted mid-phase: all registers return to their reset values immediately (asynchronous), and active durations revert to `*_DUR_RST`.

## Structure
- `def.v` supplies `STATE_W`, `S_INIT`, `S_G`, `S_Y`, `S_R`, `S_END`, `S_ZVEC` and `CNT_W`. Add `CFG_SEL_W` = 2 and the `CFG_INIT`/`CFG_G`/`CFG_Y`/`CFG_R` select codes there.
- Sub-module `sync_edge`: 2-flop synchronizer plus rising-edge detector, with async reset. Reusable for future pedestrian inputs.
- Everything else is flat in `light_dp`.

## Test plan
- **Default cycle.** Reset, FSM in the loop, defaults. Required:
  - INIT lasts 4 cycles, G 20, Y 5, R 15.
  - Each `fb_flags` bit is high exactly on the last cycle of its phase.
  - Lamps follow the phases with 1-cycle lag.
- **Config commit.** Write G=3 via cfg during G. Required:
  - The current G still lasts 20 cycles.
  - After the next INIT commit, G lasts 3.
  - `cfg_ready` is low only on the commit cycle.
- **Zero duration.** Write Y=0. Required: Y lasts 1 cycle after commit, and `fb_flags[S_Y]` is high on entry.
- **Pass and holdoff.** Pulse `emg_req` during G at `cnt`=7, with a second pulse 5 cycles later. Required:
  - `pass` is high for 1 cycle, 3 cycles after the first pulse.
  - The second pulse is ignored.
  - A third pulse 20 cycles later produces `pass`.
- **Illegal state.** Force `curr_state`=5'b00110. Required:
  - `state_err` sets and stays set.
  - `lamp_r`=1.
  - `cnt` holds.
- **Reset mid-phase.** Assert `reset` mid-R with shadow/active G=3. Required: all outputs return to their reset values asynchronously, and G reverts to 20.
